// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32x32 multiply/divide unit that owns the MIPS HI/LO
// registers. It retires one multiplier or quotient bit per cycle and uses a
// start/busy/done handshake so the control unit can stall around it.
// Build option: define MULDIV_DIV_EN to compile in the DIVU/DIV datapath.
// Without it, divide requests complete immediately and leave HI/LO unchanged.

module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [4:0] LAST_ITER = 5'd31;

  // Two's-complement negate when the flag is set; used both to take operand
  // magnitudes and to restore result signs.
  function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] cond_neg64(input logic [63:0] v, input logic neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

  // Control state
  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Datapath state. For multiply, acc holds the growing product and opb
  // shifts the multiplier out LSB first. For divide, acc[63:32] is the
  // partial remainder, acc[31:0] collects quotient bits, and opa shifts the
  // dividend out MSB first.
  logic [63:0] acc_q, acc_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic        prod_neg_q, prod_neg_d;

`ifdef MULDIV_DIV_EN
  logic        is_div_q, is_div_d;
  logic        quo_neg_q, quo_neg_d;
  logic        rem_neg_q, rem_neg_d;
`endif

  // Operand signs only matter for the signed ops (op[0]=1).
  logic a_neg, b_neg;
  assign a_neg = op[0] & a[31];
  assign b_neg = op[0] & b[31];

  // Whether a request in IDLE launches an iterative operation.
  logic launch_ok;
`ifdef MULDIV_DIV_EN
  assign launch_ok = 1'b1;
`else
  assign launch_ok = ~op[1];
`endif

  // Shift-add step: add the multiplicand into the upper half when the
  // current multiplier bit is set; the 33-bit sum keeps the carry.
  logic [32:0] mul_sum;
  assign mul_sum = {1'b0, acc_q[63:32]} + (opb_q[0] ? {1'b0, opa_q} : 33'd0);

  logic [63:0] mul_prod;
  assign mul_prod = cond_neg64(acc_q, prod_neg_q);

`ifdef MULDIV_DIV_EN
  // Restoring-division step: bring down the next dividend bit and compare the
  // 33-bit shifted remainder against the divisor.
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_rem;
  assign div_shift = {acc_q[63:32], opa_q[31]};
  assign div_ge    = (div_shift >= {1'b0, opb_q});
  assign div_rem   = div_shift[31:0] - opb_q;
`endif

  // Next-state logic for the IDLE -> RUN -> FIX sequence.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;
    acc_d      = acc_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    prod_neg_d = prod_neg_q;
`ifdef MULDIV_DIV_EN
    is_div_d   = is_div_q;
    quo_neg_d  = quo_neg_q;
    rem_neg_d  = rem_neg_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (launch_ok) begin
            opa_d      = cond_neg32(a, a_neg);
            opb_d      = cond_neg32(b, b_neg);
            prod_neg_d = a_neg ^ b_neg;
            acc_d      = 64'd0;
            cnt_d      = 5'd0;
            busy_d     = 1'b1;
            state_d    = S_RUN;
`ifdef MULDIV_DIV_EN
            is_div_d   = op[1];
            // A zero divisor leaves the all-ones quotient uncorrected so that
            // LO reads 0xFFFFFFFF regardless of the dividend sign.
            quo_neg_d  = (a_neg ^ b_neg) & (b != 32'd0);
            rem_neg_d  = a_neg;
`endif
          end else begin
            // Divide requested in a build without the divider: acknowledge at
            // once and leave HI/LO untouched.
            done_d = 1'b1;
          end
        end
      end

      S_RUN: begin
`ifdef MULDIV_DIV_EN
        if (is_div_q) begin
          opa_d = {opa_q[30:0], 1'b0};
          acc_d = {(div_ge ? div_rem : div_shift[31:0]), acc_q[30:0], div_ge};
        end else
`endif
        begin
          opb_d = {1'b0, opb_q[31:1]};
          acc_d = {mul_sum, acc_q[31:1]};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST_ITER) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
`ifdef MULDIV_DIV_EN
        if (is_div_q) begin
          hi_d = cond_neg32(acc_q[63:32], rem_neg_q);
          lo_d = cond_neg32(acc_q[31:0], quo_neg_q);
        end else
`endif
        begin
          hi_d = mul_prod[63:32];
          lo_d = mul_prod[31:0];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Control and architectural HI/LO registers; reset discards any operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Iteration datapath; always reloaded on launch, so it needs no reset.
  always_ff @(posedge clk) begin
    acc_q      <= acc_d;
    opa_q      <= opa_d;
    opb_q      <= opb_d;
    prod_neg_q <= prod_neg_d;
`ifdef MULDIV_DIV_EN
    is_div_q   <= is_div_d;
    quo_neg_q  <= quo_neg_d;
    rem_neg_q  <= rem_neg_d;
`endif
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle integer multiply/divide unit for the MIPS core, replacing the single-cycle combinational multiplier in front of the HI/LO special registers. It consumes the two register-file read operands and an operation code, iterates one bit per cycle, and owns the HI/LO result registers read by MFHI/MFLO. A start/busy/done handshake lets the control unit stall the pipeline while an operation is in flight.

## Interface
- No parameters; datapath width fixed at 32 bits.
- clk  in  1  clock; reset reset, synchronous, active-high; clock clk.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled on rising edge, accepted only when busy=0.
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- a  in  32  multiplicand / dividend (rs).
- b  in  32  multiplier / divisor (rt).
- busy  out  1  operation in flight; control stalls MFHI/MFLO and new MULT/DIV while high.
- done  out  1  one-cycle pulse; HI/LO hold the new result in the same cycle.
- hi  out  32  HI register: product[63:32] or remainder.
- lo  out  32  LO register: product[31:0] or quotient.

## Operation
- States: IDLE, RUN, FIX.
- IDLE: on start=1, latch op, |a|, |b| (magnitudes for signed ops; raw for unsigned), result signs, clear 64-bit accumulator and 5-bit iteration counter; go RUN.
- RUN, multiply: shift-add, one multiplier bit per cycle, 64-bit accumulator, no truncation.
- RUN, divide: restoring division, one quotient bit per cycle; 33-bit trial subtract of remainder minus divisor.
- After 32 iterations (counter 31) go FIX.
- FIX: apply sign correction (product negated if a[31]^b[31] for MULT; quotient negated if signs differ, remainder takes sign of dividend for DIV); write hi/lo; pulse done; go IDLE.
- Divide by zero (b=0, DIVU or DIV): normal latency; lo=0xFFFFFFFF, hi=a unchanged.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (falls out of the magnitude algorithm; no special case).
- start while busy=1: ignored; latched operands unaffected.
- hi/lo change only in FIX (and on reset); they hold between operations.

## Timing
- Reset values: busy=0, done=0, hi=0, lo=0, state IDLE, counter 0.
- start accepted at edge N -> busy=1 after edges N..N+32 (33 cycles); done=1 and new hi/lo after edge N+33; busy=0 in that same cycle.
- start in the done cycle is accepted (back-to-back), next done after edge N+66.
- busy is a registered output; no combinational path from start to busy or done.
- Reset mid-operation (any state): next cycle is IDLE, busy=0, done=0, hi=lo=0; partial result discarded; a start in the same cycle as reset is ignored.

## Configuration
- MULDIV_DIV_EN defined: divider compiled in; DIVU/DIV behave as above.
- MULDIV_DIV_EN undefined: no divide datapath; a start with op[1]=1 is accepted from IDLE, busy stays 0, done pulses in the cycle after edge N, hi/lo unchanged. Multiply behaviour and timing identical in both builds.

## Test plan
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> after 33 cycles done=1, hi=0xFFFFFFFE, lo=0x00000001; busy high exactly 33 cycles.
- MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; then back-to-back MULTU 0x10000 x 0x10000 started in the done cycle -> hi=0x00000001, lo=0.
- DIVU a=100 b=7 -> lo=14, hi=2; DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=5 b=0 -> done after 33 cycles, lo=0xFFFFFFFF, hi=5; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MULTU 6x7 started, start with a=9,b=9 pulsed at cycle 5 -> ignored, result hi=0 lo=42; second run reset at iteration 10 -> busy=0, hi=lo=0 next cycle, following MULTU 3x4 -> lo=12.
- Build without MULDIV_DIV_EN: after MULTU 2x3 (lo=6), DIVU 9/3 -> done one cycle later, busy never 1, hi=0, lo=6.
